// File: rtl/safe_pkg.sv
// safe_pkg: shared state encoding, digit geometry and BCD helper for the safe controller
package safe_pkg;
    localparam int N_DIGITS = 3;
    localparam int BCD_W = 4;
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ENTRY    = 3'd1,
        S_CHECK    = 3'd2,
        S_UNLOCKED = 3'd3,
        S_LOCKOUT  = 3'd4
    } state_t;
    // one encoder detent on a BCD digit, wrapping 9->0 and 0->9
    function automatic logic [BCD_W-1:0] bcd_step(input logic [BCD_W-1:0] d, input logic up);
        return up ? ((d == 4'd9) ? 4'd0 : d + 4'd1) : ((d == 4'd0) ? 4'd9 : d - 4'd1);
    endfunction
endpackage

// File: rtl/safe_ctrl_if.sv
// safe_ctrl_if: display-update bundle
//   master (controller): drives digit, pos, st, disp_req; receives disp_ack
//   slave  (display)   : receives digit, pos, st, disp_req; drives disp_ack
interface safe_ctrl_if;
    import safe_pkg::*;
    logic [BCD_W-1:0] digit;
    logic [1:0] pos;
    logic [2:0] st;
    logic disp_req;
    logic disp_ack;
    modport master(output digit, pos, st, disp_req, input disp_ack);
    modport slave(input digit, pos, st, disp_req, output disp_ack);
endinterface

// File: rtl/safe_input_cond.sv
// safe_input_cond: synchronizes raw inputs, divides sample ticks, edge-detects buttons, decodes quadrature
//   in : clk, reset (sync, active-low), a, b (encoder), lock, open (buttons), door (door switch)
//   out: tick (sample strobe), step_up/step_dn/lock_ev/open_ev (1-cycle pulses), door_cls (level)
module safe_input_cond #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    input  logic lock,
    input  logic open,
    input  logic door,
    output logic tick,
    output logic step_up,
    output logic step_dn,
    output logic lock_ev,
    output logic open_ev,
    output logic door_cls
);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    logic [DW-1:0] div_cnt;
    logic [4:0] s1, s2;
    logic [2:0] prev, rise;
    assign tick = div_cnt == DW'(DIV - 1);
    // s2 bits: {door, open, lock, b, a}; prev holds last sampled {open, lock, a}
    assign rise = {s2[3], s2[2], s2[0]} & ~prev;
    assign step_up = tick & rise[0] & ~s2[1];
    assign step_dn = tick & rise[0] & s2[1];
    assign lock_ev = tick & rise[1];
    assign open_ev = tick & rise[2];
    assign door_cls = s2[4];
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_cnt <= '0;
            s1 <= '0;
            s2 <= '0;
            prev <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DW'(1);
            s1 <= {door, open, lock, b, a};
            s2 <= s1;
            if (tick) prev <= {s2[3], s2[2], s2[0]};
        end
    end
endmodule

// File: rtl/safe_ctrl.sv
// safe_ctrl: three-digit combination safe controller with lockout, code change and display handshake
//   in : clk, reset (sync, active-low), a, b, lock, open, doorCls (raw, asynchronous)
//   out: actuateLock (1 = bolt engaged)
//   disp (safe_ctrl_if.master): digit, pos, st, disp_req out; disp_ack in
module safe_ctrl import safe_pkg::*; #(
    parameter int DIV = 1,
    parameter logic [N_DIGITS*BCD_W-1:0] DEFAULT_CODE = 12'h123,
    parameter int MAX_FAIL = 3,
    parameter int LOCKOUT_TICKS = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    input  logic lock,
    input  logic open,
    input  logic doorCls,
    output logic actuateLock,
    safe_ctrl_if.master disp
);
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int LW = (LOCKOUT_TICKS > 1) ? $clog2(LOCKOUT_TICKS) : 1;
    logic tick, step_up, step_dn, lock_ev, open_ev, door_cls;
    logic open_e, up, dn, last, match;
    state_t state;
    logic [BCD_W-1:0] digit;
    logic [1:0] pos;
    logic [BCD_W-1:0] entry [N_DIGITS];
    logic [N_DIGITS*BCD_W-1:0] code;
    logic set_mode;
    logic [FW-1:0] fail_cnt, fail_nxt;
    logic [LW-1:0] lock_cnt;
    logic [8:0] shown;
    logic disp_req;

    safe_input_cond #(.DIV(DIV)) u_cond (
        .clk(clk), .reset(reset), .a(a), .b(b), .lock(lock), .open(open), .door(doorCls),
        .tick(tick), .step_up(step_up), .step_dn(step_dn), .lock_ev(lock_ev),
        .open_ev(open_ev), .door_cls(door_cls)
    );

    // lock beats open beats encoder; losers in the same cycle are dropped
    assign open_e = open_ev & ~lock_ev;
    assign up = step_up & ~lock_ev & ~open_ev;
    assign dn = step_dn & ~lock_ev & ~open_ev;
    assign last = pos == 2'(N_DIGITS - 1);
    assign match = {entry[0], entry[1], entry[2]} == code;
    assign fail_nxt = fail_cnt + FW'(1);

    assign disp.digit = digit;
    assign disp.pos = pos;
    assign disp.st = state;
    assign disp.disp_req = disp_req;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
            actuateLock <= 1'b1;
            digit <= '0;
            pos <= '0;
            entry <= '{default: '0};
            code <= DEFAULT_CODE;
            set_mode <= 1'b0;
            fail_cnt <= '0;
            lock_cnt <= '0;
            shown <= {S_IDLE, 4'd0, 2'd0};
            disp_req <= 1'b0;
        end else begin
            // shown trails the displayed values by one cycle, so a difference is a fresh change
            shown <= {state, digit, pos};
            disp_req <= ({state, digit, pos} != shown) | (disp_req & ~disp.disp_ack);
            case (state)
                S_IDLE: if (open_e | up | dn) begin
                    state <= S_ENTRY;
                    digit <= '0;
                    pos <= '0;
                    set_mode <= 1'b0;
                end
                S_ENTRY: if (lock_ev) begin
                    state <= S_IDLE;
                    actuateLock <= 1'b1;
                    digit <= '0;
                    pos <= '0;
                    set_mode <= 1'b0;
                end else if (open_e) begin
                    entry[pos] <= digit;
                    digit <= '0;
                    pos <= last ? 2'd0 : pos + 2'd1;
                    if (last && set_mode) begin
                        code <= {entry[0], entry[1], digit};
                        state <= S_UNLOCKED;
                        set_mode <= 1'b0;
                    end else if (last) state <= S_CHECK;
                end else if (up | dn) digit <= bcd_step(digit, up);
                S_CHECK: if (match) begin
                    state <= S_UNLOCKED;
                    actuateLock <= 1'b0;
                    fail_cnt <= '0;
                end else begin
                    fail_cnt <= fail_nxt;
                    lock_cnt <= '0;
                    state <= (fail_nxt == FW'(MAX_FAIL)) ? S_LOCKOUT : S_IDLE;
                end
                S_UNLOCKED: if (lock_ev) begin
                    if (door_cls) begin
                        state <= S_IDLE;
                        actuateLock <= 1'b1;
                    end
                end else if (open_e && door_cls) begin
                    state <= S_ENTRY;
                    set_mode <= 1'b1;
                    digit <= '0;
                    pos <= '0;
                end
                S_LOCKOUT: if (tick) begin
                    if (lock_cnt == LW'(LOCKOUT_TICKS - 1)) begin
                        state <= S_IDLE;
                        fail_cnt <= '0;
                    end else lock_cnt <= lock_cnt + LW'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
